// File: rtl/binop_sweep_pkg.sv
// Shared types and helpers for the binary-operator sweep generator.
package binop_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Upper bounds for the width-generic helpers below. MAX_RW covers
  // SIZE=8 (20*8+20). Signatures wider than MAX_SIGW are not supported.
  localparam int MAX_RW   = 180;
  localparam int MAX_SIGW = 256;

  // Mask with the low sigw bits set.
  function automatic logic [MAX_SIGW-1:0] sig_mask(input int sigw);
    sig_mask = ~({MAX_SIGW{1'b1}} << sigw);
  endfunction

  // XOR of consecutive sigw-bit chunks starting at bit 0. The caller
  // zero-extends data, so the top chunk comes out zero-padded.
  function automatic logic [MAX_SIGW-1:0] fold(input logic [MAX_RW-1:0] data,
                                               input int sigw);
    logic [MAX_SIGW-1:0] acc;
    logic [MAX_RW-1:0]   d;
    logic [MAX_SIGW-1:0] m;
    acc = '0;
    d   = data;
    m   = sig_mask(sigw);
    for (int k = 0; k < MAX_RW; k++) begin
      acc = acc ^ (MAX_SIGW'(d) & m);
      d   = d >> sigw;
    end
    return acc;
  endfunction

  // Rotate the low sigw bits of x left by one.
  function automatic logic [MAX_SIGW-1:0] rotl1(input logic [MAX_SIGW-1:0] x,
                                                input int sigw);
    logic [MAX_SIGW-1:0] m;
    logic [MAX_SIGW-1:0] xm;
    m  = sig_mask(sigw);
    xm = x & m;
    return ((xm << 1) | (xm >> (sigw - 1))) & m;
  endfunction

endpackage

// File: rtl/binop_sweep_gen_sig_acc.sv
// Running signature register: sig <= rotl1(sig) ^ fold(data) when enabled.
module binop_sig_acc
  import binop_sweep_pkg::*;
#(
  parameter int RW   = 40,
  parameter int SIGW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [RW-1:0]   data,
  output logic [SIGW-1:0] sig
);

  logic [SIGW-1:0] r_sig;

  // Clear wins over enable so a restart always begins from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= SIGW'(rotl1(MAX_SIGW'(r_sig), SIGW) ^ fold(MAX_RW'(data), SIGW));
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/binop_sweep_gen.sv
// Exhaustive operand-pair sweep for a binary-operator unit, with a
// signature over the unit's concatenated results.
//
// Handshake: src_valid is high exactly while in RUN; a pair is accepted on
// any rising edge where src_valid && src_ready. Operands, pair count and
// signature only move on accept, so they hold while src_ready is low.
module binop_sweep_gen
  import binop_sweep_pkg::*;
#(
  parameter int  SIZE = 4,
  parameter int  SIGW = 32,
  localparam int RW   = 20 * SIZE + 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [SIZE-1:0]   src1,
  output logic [SIZE-1:0]   src2,
  output logic              src_valid,
  input  logic              src_ready,
  input  logic [RW-1:0]     res_data,
  output logic [SIGW-1:0]   sig,
  output logic [2*SIZE:0]   pair_cnt,
  output logic              busy,
  output logic              done,
  output state_e            o_dbg_state
);

  localparam int CW = 2 * SIZE + 1;

  state_e          r_state;
  state_e          w_next_state;
  logic [SIZE-1:0] r_src1;
  logic [SIZE-1:0] r_src2;
  logic [CW-1:0]   r_pair_cnt;
  logic            w_accept;
  logic            w_last;
  logic            w_clr;

  assign w_accept = (r_state == S_RUN) && src_ready;
  assign w_last   = (&r_src1) && (&r_src2);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and sweep-clear; abort in RUN beats the final-pair exit,
  // and start beats abort outside RUN (abort is ignored there anyway).
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next_state = S_RUN;
          w_clr        = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (w_accept && w_last) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand counters: src2 inner loop, src1 outer; both wrap to 0 after the last pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src1     <= '0;
      r_src2     <= '0;
      r_pair_cnt <= '0;
    end else if (w_clr) begin
      r_src1     <= '0;
      r_src2     <= '0;
      r_pair_cnt <= '0;
    end else if (w_accept) begin
      r_pair_cnt <= r_pair_cnt + CW'(1);
      r_src2     <= r_src2 + SIZE'(1);
      if (&r_src2) begin
        r_src1 <= r_src1 + SIZE'(1);
      end
    end
  end

  binop_sig_acc #(
    .RW   (RW),
    .SIGW (SIGW)
  ) u_sig_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .en    (w_accept),
    .data  (res_data),
    .sig   (sig)
  );

  assign src1        = r_src1;
  assign src2        = r_src2;
  assign pair_cnt    = r_pair_cnt;
  assign src_valid   = (r_state == S_RUN);
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule
